// File: rtl/hdmi_pkg.sv
// Shared HDMI-path types and constants, also imported by the timing generator.
//   coord_t  : 10-bit pixel coordinate
//   rgb12_t  : {R4,G4,B4} pixel colour
//   pos_t    : sprite position payload {x, y}
//   sync_t   : sync/data-enable bundle carried down the pipeline
package hdmi_pkg;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned COORD_W  = 10;
   localparam int unsigned RGB_W    = 12;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [RGB_W-1:0]   rgb12_t;

   localparam rgb12_t PLAYER_RGB_DFLT = 12'hFF0;
   localparam rgb12_t STAR_RGB_DFLT   = 12'hFFF;
   localparam rgb12_t BG_RGB_DFLT     = 12'h001;
   localparam rgb12_t BLANK_RGB       = 12'h000;

   typedef struct packed {
      coord_t x;
      coord_t y;
   } pos_t;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic de;
   } sync_t;

endpackage

// File: rtl/pixel_renderer_if.sv
// Pixel-stream and sprite-position bus between the timing generator/game logic
// and the renderer.
//   master : drives p_clock, x, y, hsync, vsync, video_on, pos_x, pos_y, pos_valid;
//            receives rgb, hsync_out, vsync_out, de_out, frame_tick
//   slave  : the renderer side (directions reversed)
interface pixel_renderer_if
   import hdmi_pkg::*;
   ;

   logic   p_clock;
   coord_t x;
   coord_t y;
   logic   hsync;
   logic   vsync;
   logic   video_on;
   coord_t pos_x;
   coord_t pos_y;
   logic   pos_valid;
   rgb12_t rgb;
   logic   hsync_out;
   logic   vsync_out;
   logic   de_out;
   logic   frame_tick;

   modport master (
      output p_clock, x, y, hsync, vsync, video_on, pos_x, pos_y, pos_valid,
      input  rgb, hsync_out, vsync_out, de_out, frame_tick
   );

   modport slave (
      input  p_clock, x, y, hsync, vsync, video_on, pos_x, pos_y, pos_valid,
      output rgb, hsync_out, vsync_out, de_out, frame_tick
   );

endinterface

// File: rtl/starfield_gen.sv
// Combinational starfield hash: decides whether (x, y+scroll) is a star.
//   i_x, i_y     : current pixel coordinate
//   i_scroll     : vertical scroll offset in lines
//   o_star_hit_c : 1 when the pixel lies on a star
module starfield_gen
   import hdmi_pkg::*;
(
   input  coord_t i_x,
   input  coord_t i_y,
   input  coord_t i_scroll,
   output logic   o_star_hit_c
);

   coord_t w_ys;
   coord_t w_h;

   // Scrolled row, rotated by 5 bits and mixed with the column.
   assign w_ys         = i_y + i_scroll;
   assign w_h          = i_x ^ {w_ys[4:0], w_ys[9:5]};
   assign o_star_hit_c = (w_h[5:0] == 6'h2A) && (i_x[3] ^ w_ys[2]);

endmodule

// File: rtl/pixel_renderer.sv
// Two-stage pixel renderer: starfield background plus one player sprite, with
// hsync/vsync/de delayed to line up with rgb. Sprite position is double-buffered
// and only taken over at the frame latch point (x==0, y==V_ACTIVE).
//   clk, reset : clock and synchronous active-low reset
//   bus        : slave side of pixel_renderer_if (pixel stream in, rgb/syncs out,
//                sprite-position strobe, frame_tick)
module pixel_renderer
   import hdmi_pkg::*;
#(
   parameter int unsigned STAR_SPEED = 1,
   parameter int unsigned SPRITE_W   = 16,
   parameter int unsigned SPRITE_H   = 16,
   parameter rgb12_t      PLAYER_RGB = PLAYER_RGB_DFLT,
   parameter rgb12_t      STAR_RGB   = STAR_RGB_DFLT,
   parameter rgb12_t      BG_RGB     = BG_RGB_DFLT
)(
   input  logic              clk,
   input  logic              reset,
   pixel_renderer_if.slave   bus
);

   pos_t   r_pending;
   pos_t   r_active;
   coord_t r_scroll;
   logic   r_frame_tick;

   logic   r_s1_sprite;
   logic   r_s1_star;
   sync_t  r_s1_sync;

   rgb12_t r_rgb;
   sync_t  r_s2_sync;

   logic   w_latch;
   coord_t w_dx;
   coord_t w_dy;
   logic   w_sprite_hit;
   logic   w_star_hit;

   // Frame latch point: first pixel of the first line below the visible area.
   assign w_latch = bus.p_clock && (bus.x == '0) && (bus.y == coord_t'(V_ACTIVE));

   // Position buffers and scroll; a strobe on the latch clk bypasses pending.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pending    <= '0;
         r_active     <= '0;
         r_scroll     <= '0;
         r_frame_tick <= 1'b0;
      end else begin
         r_frame_tick <= w_latch;
         if (bus.pos_valid) begin
            r_pending.x <= bus.pos_x;
            r_pending.y <= bus.pos_y;
         end
         if (w_latch) begin
            r_scroll <= r_scroll + coord_t'(STAR_SPEED);
            if (bus.pos_valid) begin
               r_active.x <= bus.pos_x;
               r_active.y <= bus.pos_y;
            end else begin
               r_active <= r_pending;
            end
         end
      end
   end

   // Unsigned wrap makes pixels left of / above the sprite fail the range test.
   assign w_dx         = bus.x - r_active.x;
   assign w_dy         = bus.y - r_active.y;
   assign w_sprite_hit = (w_dx < coord_t'(SPRITE_W)) && (w_dy < coord_t'(SPRITE_H));

   starfield_gen u_starfield (
      .i_x          (bus.x),
      .i_y          (bus.y),
      .i_scroll     (r_scroll),
      .o_star_hit_c (w_star_hit)
   );

   // Stage 1: hit flags and sync capture.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_s1_sprite <= 1'b0;
         r_s1_star   <= 1'b0;
         r_s1_sync   <= '0;
      end else if (bus.p_clock) begin
         r_s1_sprite     <= w_sprite_hit;
         r_s1_star       <= w_star_hit;
         r_s1_sync.hsync <= bus.hsync;
         r_s1_sync.vsync <= bus.vsync;
         r_s1_sync.de    <= bus.video_on;
      end
   end

   // Stage 2: colour priority (blank > sprite > star > background).
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rgb     <= '0;
         r_s2_sync <= '0;
      end else if (bus.p_clock) begin
         r_s2_sync <= r_s1_sync;
         if (!r_s1_sync.de)    r_rgb <= BLANK_RGB;
         else if (r_s1_sprite) r_rgb <= PLAYER_RGB;
         else if (r_s1_star)   r_rgb <= STAR_RGB;
         else                  r_rgb <= BG_RGB;
      end
   end

   assign bus.rgb        = r_rgb;
   assign bus.hsync_out  = r_s2_sync.hsync;
   assign bus.vsync_out  = r_s2_sync.vsync;
   assign bus.de_out     = r_s2_sync.de;
   assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_pixel_renderer.sv
// Self-checking bench for pixel_renderer: table-driven sprite/latch/blanking
// vectors plus hand-written reset, scroll-wrap and p_clock-freeze sequences.
module tb_pixel_renderer;
   import hdmi_pkg::*;

   localparam int unsigned SPEED = 15;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   pixel_renderer_if bus_if ();

   pixel_renderer #(.STAR_SPEED(SPEED)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   typedef struct packed {
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
      logic        de;
   } exp_t;

   typedef struct {
      int          x;
      int          y;
      bit          von;
      bit          pv;
      int          nx;
      int          ny;
      bit          ovr;
      logic [11:0] rgb;
   } vec_t;

   exp_t sb_q[$];
   exp_t last_exp;
   int   n_checks = 0;
   int   n_fail   = 0;

   int m_pend_x, m_pend_y, m_act_x, m_act_y, m_scroll;

   // Reference colour for a pixel given the bench's view of active/scroll.
   function automatic logic [11:0] model_rgb(int px, int py, bit von);
      int ys, rot, h;
      bit star, spr;
      if (!von) return 12'h000;
      ys   = (py + m_scroll) % 1024;
      rot  = ((ys % 32) * 32) + (ys / 32);
      h    = px ^ rot;
      star = ((h % 64) == 42) && ((((px / 8) % 2) ^ ((ys / 4) % 2)) == 1);
      spr  = (((px - m_act_x + 1024) % 1024) < 16) && (((py - m_act_y + 1024) % 1024) < 16);
      if (spr)  return 12'hFF0;
      if (star) return 12'hFFF;
      return 12'h001;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         if (n_fail <= 25)
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, req, $time);
      end
   endtask

   // One clk: drive at negedge, update model at posedge, compare #1 later.
   task automatic step(input bit rst_n, input bit pclk, input int px, input int py,
                       input bit hs, input bit vs, input bit von,
                       input bit pv, input int nx, input int ny,
                       input bit ovr, input logic [11:0] ovr_rgb);
      bit   latch;
      exp_t e;
      @(negedge clk);
      reset            = rst_n;
      bus_if.p_clock   = pclk;
      bus_if.x         = coord_t'(px);
      bus_if.y         = coord_t'(py);
      bus_if.hsync     = hs;
      bus_if.vsync     = vs;
      bus_if.video_on  = von;
      bus_if.pos_valid = pv;
      bus_if.pos_x     = coord_t'(nx);
      bus_if.pos_y     = coord_t'(ny);
      latch = rst_n && pclk && (px == 0) && (py == 480);
      if (rst_n && pclk) begin
         e.rgb = ovr ? ovr_rgb : model_rgb(px, py, von);
         e.hs  = hs;
         e.vs  = vs;
         e.de  = von;
         sb_q.push_back(e);
      end
      @(posedge clk);
      if (!rst_n) begin
         m_pend_x = 0; m_pend_y = 0; m_act_x = 0; m_act_y = 0; m_scroll = 0;
         sb_q.delete();
         last_exp = '0;
      end else begin
         if (latch) begin
            m_act_x  = pv ? nx : m_pend_x;
            m_act_y  = pv ? ny : m_pend_y;
            m_scroll = (m_scroll + SPEED) % 1024;
         end
         if (pv) begin
            m_pend_x = nx;
            m_pend_y = ny;
         end
      end
      #1;
      if (rst_n && pclk && sb_q.size() == 2) last_exp = sb_q.pop_front();
      chk("rgb",        32'(bus_if.rgb),        32'(last_exp.rgb));
      chk("hsync_out",  32'(bus_if.hsync_out),  32'(last_exp.hs));
      chk("vsync_out",  32'(bus_if.vsync_out),  32'(last_exp.vs));
      chk("de_out",     32'(bus_if.de_out),     32'(last_exp.de));
      chk("frame_tick", 32'(bus_if.frame_tick), 32'(latch));
   endtask

   task automatic pix(input int px, input int py, input bit von);
      step(1'b1, 1'b1, px, py, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           von, 1'b0, 0, 0, 1'b0, 12'h000);
   endtask

   task automatic latch_frame(input bit pv, input int nx, input int ny);
      step(1'b1, 1'b1, 0, 480, 1'b0, 1'b1, 1'b0, pv, nx, ny, 1'b0, 12'h000);
   endtask

   vec_t vecs[$];

   initial begin
      bus_if.p_clock = 1'b0; bus_if.x = '0; bus_if.y = '0;
      bus_if.hsync = 1'b0; bus_if.vsync = 1'b0; bus_if.video_on = 1'b0;
      bus_if.pos_x = '0; bus_if.pos_y = '0; bus_if.pos_valid = 1'b0;
      last_exp = '0;

      // Reset held 4 clk with p_clock toggling, a strobe and the latch coordinate.
      for (int i = 0; i < 4; i++)
         step(1'b0, 1'(i % 2), 0, 480, 1'b1, 1'b1, 1'b1, 1'b1, 300, 300, 1'b0, 12'h000);

      // Latency: de/rgb appear exactly two ticks after the first visible pixel.
      pix(99, 50, 1'b0);
      pix(100, 50, 1'b1);
      pix(101, 50, 1'b1);
      pix(102, 50, 1'b0);
      pix(103, 50, 1'b1);

      // Sprite/latch/blanking vectors: {x, y, von, pv, nx, ny, ovr, rgb}.
      vecs = '{
         '{100, 200, 1, 1, 200, 100, 0, 12'h000},
         '{200, 100, 1, 0,   0,   0, 0, 12'h000},
         '{207, 108, 1, 0,   0,   0, 0, 12'h000},
         '{  0, 480, 0, 0,   0,   0, 0, 12'h000},
         '{200, 100, 1, 0,   0,   0, 1, 12'hFF0},
         '{215, 115, 1, 0,   0,   0, 1, 12'hFF0},
         '{216, 100, 1, 0,   0,   0, 0, 12'h000},
         '{199, 100, 1, 0,   0,   0, 0, 12'h000},
         '{215, 116, 1, 0,   0,   0, 0, 12'h000},
         '{205, 105, 0, 0,   0,   0, 1, 12'h000},
         '{300, 300, 1, 1, 400, 400, 0, 12'h000},
         '{210, 110, 1, 0,   0,   0, 1, 12'hFF0},
         '{  0, 480, 0, 1,  10,  20, 0, 12'h000},
         '{ 10,  20, 1, 0,   0,   0, 1, 12'hFF0},
         '{ 25,  35, 1, 0,   0,   0, 1, 12'hFF0},
         '{ 26,  20, 1, 0,   0,   0, 0, 12'h000},
         '{  9,  20, 1, 0,   0,   0, 0, 12'h000},
         '{200, 100, 1, 0,   0,   0, 0, 12'h000},
         '{ 50,  50, 1, 1, 500, 400, 0, 12'h000},
         '{ 51,  50, 1, 1, 600, 300, 0, 12'h000},
         '{  0, 480, 0, 0,   0,   0, 0, 12'h000},
         '{600, 300, 1, 0,   0,   0, 1, 12'hFF0},
         '{500, 400, 1, 0,   0,   0, 0, 12'h000},
         '{605, 310, 0, 0,   0,   0, 1, 12'h000}
      };
      foreach (vecs[i])
         step(1'b1, 1'b1, vecs[i].x, vecs[i].y, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), vecs[i].von, vecs[i].pv,
              vecs[i].nx, vecs[i].ny, vecs[i].ovr, vecs[i].rgb);

      // Scroll wrap: fresh reset, sprite parked off-screen, 69 frame latches.
      step(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 12'h000);
      step(1'b1, 1'b1, 500, 500, 1'b0, 1'b0, 1'b1, 1'b1, 1000, 1000, 1'b0, 12'h000);
      for (int f = 0; f < 69; f++) begin
         latch_frame(1'b0, 0, 0);
         pix($urandom_range(0, 639), $urandom_range(0, 479), 1'b1);
      end

      // Star pattern over every visible row, aiming at the hash's hit columns.
      for (int yy = 0; yy < 480; yy++) begin
         int ys, rot, xs;
         ys  = (yy + 11) % 1024;
         rot = ((ys % 32) * 32) + (ys / 32);
         xs  = (42 ^ rot) % 64;
         pix(xs, yy, 1'b1);
         pix(xs + 64 * $urandom_range(1, 8), yy, 1'b1);
         pix($urandom_range(0, 639), yy, 1'b1);
      end

      // p_clock low for 10 clk mid-line: outputs hold, no latch, strobe still captured.
      pix(300, 200, 1'b1);
      pix(301, 200, 1'b0);
      for (int i = 0; i < 10; i++)
         step(1'b1, 1'b0, (i % 2 == 0) ? 0 : 320 + i, 480, 1'(i % 2), 1'((i / 2) % 2),
              1'b1, (i == 4), 30, 40, 1'b0, 12'h000);
      pix(302, 200, 1'b1);
      pix(303, 200, 1'b1);
      latch_frame(1'b0, 0, 0);
      pix(30, 40, 1'b1);
      pix(45, 55, 1'b1);
      pix(46, 40, 1'b1);
      pix(30, 40, 1'b0);
      pix(100, 100, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
